// File: rtl/cv32e40p_apu_arbiter_if.sv
// rtl/cv32e40p_apu_arbiter_if.sv - requester-side and APU-side handshake bundle for the APU arbiter
interface cv32e40p_apu_arbiter_if #(
    parameter int NUM_REQ          = 2,
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5
);
    logic [NUM_REQ-1:0]                          req_i;
    logic [NUM_REQ-1:0]                          gnt_o;
    logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0] operands_i;
    logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]         op_i;
    logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]    flags_i;
    logic [NUM_REQ-1:0]                          rvalid_o;
    logic [31:0]                                 result_o;
    logic [APU_NUSFLAGS_CPU-1:0]                 rflags_o;

    logic                                        apu_req_o;
    logic                                        apu_gnt_i;
    logic [APU_NARGS_CPU-1:0][31:0]              apu_operands_o;
    logic [APU_WOP_CPU-1:0]                      apu_op_o;
    logic [APU_NDSFLAGS_CPU-1:0]                 apu_flags_o;
    logic                                        apu_rvalid_i;
    logic [31:0]                                 apu_result_i;
    logic [APU_NUSFLAGS_CPU-1:0]                 apu_rflags_i;

    modport slave (
        input  req_i, operands_i, op_i, flags_i,
        input  apu_gnt_i, apu_rvalid_i, apu_result_i, apu_rflags_i,
        output gnt_o, rvalid_o, result_o, rflags_o,
        output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
    );

    modport master (
        output req_i, operands_i, op_i, flags_i,
        output apu_gnt_i, apu_rvalid_i, apu_result_i, apu_rflags_i,
        input  gnt_o, rvalid_o, result_o, rflags_o,
        input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
    );
endinterface

// File: rtl/cv32e40p_apu_arbiter.sv
// rtl/cv32e40p_apu_arbiter.sv - round-robin APU sharing with in-order response routing via an ID FIFO
// Define CV32E40P_APU_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module cv32e40p_apu_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    cv32e40p_apu_arbiter_if.slave             bus,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
    output logic                              busy_o,
    output logic                              err_o
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = $clog2(MAX_OUTSTANDING);

    typedef enum logic {IDLE, WAIT_GNT} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   locked_id_q;
    logic [IDW-1:0]   winner;
    logic             winner_vld;
    logic [IDW-1:0]   sel;
    logic             have_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             apu_req;
    logic             grant;
    logic             pop;
    logic [IDW-1:0]   id_fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             err_q;

`ifdef CV32E40P_APU_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the last to assign.
    always_comb begin
        logic [IDW-1:0] idx;
        winner     = '0;
        winner_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDW'(i);
            if (bus.req_i[idx]) begin
                winner     = idx;
                winner_vld = 1'b1;
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr_q;

    // Descending scan over offsets so the first requester at or after rr_ptr wins.
    always_comb begin
        logic [IDW-1:0] idx;
        winner     = '0;
        winner_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (bus.req_i[idx]) begin
                winner     = idx;
                winner_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (grant) begin
            rr_ptr_q <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
        end
    end
`endif

    assign sel        = (state_q == WAIT_GNT) ? locked_id_q : winner;
    assign have_req   = winner_vld | (state_q == WAIT_GNT);
    assign fifo_full  = (count_q == (PW+1)'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    // Full blocks requests regardless of a same-cycle pop: no rvalid-to-req path.
    assign apu_req    = have_req & ~fifo_full;
    assign grant      = apu_req & bus.apu_gnt_i;
    assign pop        = bus.apu_rvalid_i & ~fifo_empty;

    assign bus.apu_req_o = apu_req;
    assign bus.gnt_o     = grant ? (NUM_REQ'(1) << sel) : '0;
    assign bus.rvalid_o  = pop ? (NUM_REQ'(1) << id_fifo_q[rd_ptr_q]) : '0;
    assign bus.result_o  = bus.apu_result_i;
    assign bus.rflags_o  = bus.apu_rflags_i;

    always_comb begin
        bus.apu_operands_o = '0;
        bus.apu_op_o       = '0;
        bus.apu_flags_o    = '0;
        if (have_req) begin
            bus.apu_operands_o = bus.operands_i[sel];
            bus.apu_op_o       = bus.op_i[sel];
            bus.apu_flags_o    = bus.flags_i[sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (apu_req && !bus.apu_gnt_i) state_d = WAIT_GNT;
            WAIT_GNT: if (grant) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_id_q <= '0;
        end else if (state_q == IDLE && apu_req && !bus.apu_gnt_i) begin
            locked_id_q <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            id_fifo_q[wr_ptr_q] <= sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (grant) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PW+1)'(grant) - (PW+1)'(pop);
            if (bus.apu_rvalid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    assign outstanding_o = count_q;
    assign busy_o        = (count_q != '0) | apu_req;
    assign err_o         = err_q;
endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// tb/tb_cv32e40p_apu_arbiter.sv - directed and randomized bench for cv32e40p_apu_arbiter
module tb_cv32e40p_apu_arbiter;
    localparam int N = 2, NARGS = 3, WOP = 6, NDS = 15, NUS = 5, MAXO = 4;
    localparam int CW = $clog2(MAXO) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] outstanding;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    cv32e40p_apu_arbiter_if #(.NUM_REQ(N), .APU_NARGS_CPU(NARGS), .APU_WOP_CPU(WOP),
        .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS)) bus ();

    cv32e40p_apu_arbiter #(.NUM_REQ(N), .APU_NARGS_CPU(NARGS), .APU_WOP_CPU(WOP),
        .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS), .MAX_OUTSTANDING(MAXO)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .outstanding_o(outstanding), .busy_o(busy), .err_o(err));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of owners, pending lock, next round-robin start.
    int         q[$];
    int         lock;
    int         nxt;
    bit         m_err;
    int         cand;
    bit         e_req;
    logic [N-1:0] e_gnt, e_rv;

    function automatic void model_reset();
        q.delete();
        lock  = -1;
        nxt   = 0;
        m_err = 1'b0;
    endfunction

    function automatic void model_eval();
        int k;
        cand = -1;
        if (lock >= 0) cand = lock;
        else begin
            for (int i = 0; i < N; i++) begin
`ifdef CV32E40P_APU_ARB_FIXED_PRIO_EN
                k = i;
`else
                k = (nxt + i) % N;
`endif
                if (cand < 0 && bus.req_i[k]) cand = k;
            end
        end
        e_req = (cand >= 0) && (q.size() < MAXO);
        e_gnt = '0;
        if (e_req && bus.apu_gnt_i) e_gnt[cand] = 1'b1;
        e_rv = '0;
        if (bus.apu_rvalid_i && q.size() > 0) e_rv[q[0]] = 1'b1;
    endfunction

    function automatic void model_commit();
        if (bus.apu_rvalid_i) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_err = 1'b1;
        end
        if (e_gnt != '0) begin
            q.push_back(cand);
            lock = -1;
            nxt  = (cand + 1) % N;
        end else if (e_req) begin
            lock = cand;
        end
    endfunction

    task automatic clk_step();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_i        = '0;
        bus.operands_i   = '0;
        bus.op_i         = '0;
        bus.flags_i      = '0;
        bus.apu_gnt_i    = 1'b0;
        bus.apu_rvalid_i = 1'b0;
        bus.apu_result_i = '0;
        bus.apu_rflags_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (bus.apu_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", bus.apu_req_o); end
        n_vec++; if (bus.gnt_o !== 2'b00) begin n_err++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt_o); end
        n_vec++; if (bus.rvalid_o !== 2'b00) begin n_err++; $display("FAIL reset_rvalid got=%b exp=00", bus.rvalid_o); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        n_vec++; if (outstanding !== 0) begin n_err++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err); end
        n_vec++; if (bus.apu_op_o !== '0) begin n_err++; $display("FAIL reset_op got=%h exp=0", bus.apu_op_o); end
        @(negedge clk);
    endtask

    task automatic test_rr_fill();
        logic [N-1:0] eg;
        do_reset();
        bus.req_i = 2'b11; bus.op_i[0] = 6'h01; bus.op_i[1] = 6'h02; bus.apu_gnt_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            eg = (i < 4) ? ((i % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            n_vec++; if (bus.gnt_o !== eg) begin n_err++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", i, bus.gnt_o, eg); end
            n_vec++; if (outstanding !== CW'((i < 4) ? i : 4)) begin n_err++; $display("FAIL rr_outstanding cyc=%0d got=%0d exp=%0d", i, outstanding, (i < 4) ? i : 4); end
            n_vec++; if (bus.apu_req_o !== (i < 4)) begin n_err++; $display("FAIL rr_apu_req cyc=%0d got=%b exp=%b", i, bus.apu_req_o, i < 4); end
            clk_step();
        end
    endtask

    task automatic test_lock();
        do_reset();
        #1;
        n_vec++; if (outstanding !== 0) begin n_err++; $display("FAIL lock_reset_clear got=%0d exp=0", outstanding); end
        bus.req_i = 2'b01; bus.op_i[0] = 6'h15; bus.op_i[1] = 6'h2a;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) bus.req_i = 2'b11;
            #1;
            n_vec++; if (bus.apu_op_o !== 6'h15) begin n_err++; $display("FAIL lock_op cyc=%0d got=%h exp=15", i, bus.apu_op_o); end
            n_vec++; if (bus.gnt_o !== 2'b00 || bus.apu_req_o !== 1'b1) begin n_err++; $display("FAIL lock_wait cyc=%0d got=%b/%b exp=00/1", i, bus.gnt_o, bus.apu_req_o); end
            clk_step();
        end
        bus.apu_gnt_i = 1'b1;
        #1;
        n_vec++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL lock_gnt got=%b exp=01", bus.gnt_o); end
        clk_step();
        #1;
`ifdef CV32E40P_APU_ARB_FIXED_PRIO_EN
        n_vec++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL lock_next_gnt got=%b exp=01", bus.gnt_o); end
`else
        n_vec++; if (bus.gnt_o !== 2'b10 || bus.apu_op_o !== 6'h2a) begin n_err++; $display("FAIL lock_next_gnt got=%b/%h exp=10/2a", bus.gnt_o, bus.apu_op_o); end
`endif
        clk_step();
    endtask

    task automatic test_routing();
        logic [N-1:0] erv;
        do_reset();
        bus.apu_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_i = (i == 1) ? 2'b01 : 2'b10;
            #1;
            n_vec++; if (bus.gnt_o !== bus.req_i) begin n_err++; $display("FAIL route_gnt n=%0d got=%b exp=%b", i, bus.gnt_o, bus.req_i); end
            clk_step();
        end
        bus.req_i = 2'b00; bus.apu_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.apu_rvalid_i = 1'b1;
            bus.apu_result_i = 32'hA + i;
            bus.apu_rflags_i = NUS'(i + 1);
            erv = (i == 1) ? 2'b01 : 2'b10;
            #1;
            n_vec++; if (bus.rvalid_o !== erv) begin n_err++; $display("FAIL route_rvalid n=%0d got=%b exp=%b", i, bus.rvalid_o, erv); end
            n_vec++; if (bus.result_o !== 32'hA + i) begin n_err++; $display("FAIL route_result n=%0d got=%h exp=%h", i, bus.result_o, 32'hA + i); end
            n_vec++; if (bus.rflags_o !== NUS'(i + 1)) begin n_err++; $display("FAIL route_rflags n=%0d got=%h exp=%h", i, bus.rflags_o, i + 1); end
            n_vec++; if (outstanding !== CW'(3 - i)) begin n_err++; $display("FAIL route_outstanding n=%0d got=%0d exp=%0d", i, outstanding, 3 - i); end
            clk_step();
        end
        bus.apu_rvalid_i = 1'b0;
        #1;
        n_vec++; if (outstanding !== 0 || busy !== 1'b0) begin n_err++; $display("FAIL route_drained got=%0d/%b exp=0/0", outstanding, busy); end
        clk_step();
    endtask

    task automatic test_simul();
        logic [N-1:0] erv;
        do_reset();
        bus.req_i = 2'b11; bus.apu_gnt_i = 1'b1;
        repeat (3) clk_step();
        bus.apu_rvalid_i = 1'b1;
        #1;
        n_vec++; if (bus.gnt_o !== 2'b10 || bus.rvalid_o !== 2'b01) begin n_err++; $display("FAIL simul_both got=%b/%b exp=10/01", bus.gnt_o, bus.rvalid_o); end
        clk_step();
        bus.req_i = 2'b00; bus.apu_gnt_i = 1'b0; bus.apu_rvalid_i = 1'b0;
        #1;
        n_vec++; if (outstanding !== 3) begin n_err++; $display("FAIL simul_occupancy got=%0d exp=3", outstanding); end
        for (int i = 0; i < 3; i++) begin
            bus.apu_rvalid_i = 1'b1;
            erv = (i == 1) ? 2'b01 : 2'b10;
            #1;
            n_vec++; if (bus.rvalid_o !== erv) begin n_err++; $display("FAIL simul_head n=%0d got=%b exp=%b", i, bus.rvalid_o, erv); end
            clk_step();
        end
        bus.apu_rvalid_i = 1'b0;
    endtask

    task automatic test_err();
        do_reset();
        bus.apu_rvalid_i = 1'b1;
        #1;
        n_vec++; if (bus.rvalid_o !== 2'b00 || err !== 1'b0) begin n_err++; $display("FAIL err_drop got=%b/%b exp=00/0", bus.rvalid_o, err); end
        clk_step();
        bus.apu_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky cyc=%0d got=%b exp=1", i, err); end
            clk_step();
        end
        do_reset();
        #1;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_cleared got=%b exp=0", err); end
        bus.req_i = 2'b01; bus.apu_gnt_i = 1'b1; bus.apu_rvalid_i = 1'b1;
        #1;
        n_vec++; if (bus.gnt_o !== 2'b01 || bus.rvalid_o !== 2'b00) begin n_err++; $display("FAIL err_same_cycle got=%b/%b exp=01/00", bus.gnt_o, bus.rvalid_o); end
        clk_step();
        idle_inputs();
        #1;
        n_vec++; if (err !== 1'b1 || outstanding !== 1) begin n_err++; $display("FAIL err_same_cycle_after got=%b/%0d exp=1/1", err, outstanding); end
        clk_step();
    endtask

`ifdef CV32E40P_APU_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        bus.req_i = 2'b11; bus.apu_gnt_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.apu_rvalid_i = (i > 0);
            #1;
            n_vec++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL fixed_gnt cyc=%0d got=%b exp=01", i, bus.gnt_o); end
            clk_step();
        end
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        logic [N-1:0]            prev_gnt;
        logic [WOP-1:0]          eo;
        logic [NDS-1:0]          ef;
        logic [NARGS-1:0][31:0]  ea;
        do_reset();
        prev_gnt = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ((bus.req_i[k] && prev_gnt[k] && ($urandom % 2 == 0)) ||
                    (!bus.req_i[k] && ($urandom % 3 == 0)) ||
                    (bus.req_i[k] && prev_gnt[k])) begin
                    bus.req_i[k]      = bus.req_i[k] && prev_gnt[k] ? 1'($urandom % 2) : 1'b1;
                    bus.op_i[k]       = WOP'($urandom);
                    bus.flags_i[k]    = NDS'($urandom);
                    bus.operands_i[k] = {$urandom, $urandom, $urandom};
                end
            end
            bus.apu_gnt_i    = 1'($urandom % 2);
            bus.apu_rvalid_i = (q.size() > 0) ? ($urandom % 3 == 0) : ($urandom % 64 == 0);
            bus.apu_result_i = $urandom;
            bus.apu_rflags_i = NUS'($urandom);
            #1;
            model_eval();
            eo = (cand >= 0) ? bus.op_i[cand] : '0;
            ef = (cand >= 0) ? bus.flags_i[cand] : '0;
            ea = (cand >= 0) ? bus.operands_i[cand] : '0;
            n_vec++; if (bus.gnt_o !== e_gnt) begin n_err++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, bus.gnt_o, e_gnt); end
            n_vec++; if (bus.apu_req_o !== e_req) begin n_err++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", c, bus.apu_req_o, e_req); end
            n_vec++; if (bus.rvalid_o !== e_rv) begin n_err++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, bus.rvalid_o, e_rv); end
            n_vec++; if (bus.result_o !== bus.apu_result_i || bus.rflags_o !== bus.apu_rflags_i) begin n_err++; $display("FAIL rnd_result cyc=%0d got=%h exp=%h", c, bus.result_o, bus.apu_result_i); end
            n_vec++; if (bus.apu_op_o !== eo || bus.apu_flags_o !== ef || bus.apu_operands_o !== ea) begin n_err++; $display("FAIL rnd_payload cyc=%0d got_op=%h exp_op=%h", c, bus.apu_op_o, eo); end
            n_vec++; if (outstanding !== CW'(q.size())) begin n_err++; $display("FAIL rnd_outstanding cyc=%0d got=%0d exp=%0d", c, outstanding, q.size()); end
            n_vec++; if (busy !== (q.size() != 0 || e_req)) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, q.size() != 0 || e_req); end
            n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err, m_err); end
            prev_gnt = e_gnt;
            clk_step();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
`ifndef CV32E40P_APU_ARB_FIXED_PRIO_EN
        test_rr_fill();
        test_simul();
`endif
        test_lock();
        test_routing();
        test_err();
`ifdef CV32E40P_APU_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
